// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped write-back data cache.
package dcache_pkg;

  localparam int unsigned TAG_W  = 25;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned OFS_W  = 2;
  localparam int unsigned LINE_W = 128;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    ALLOCATE
  } state_e;

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage for dcache: combinational read by index,
// synchronous line fill, word write and dirty clear.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int unsigned NUM_SETS       = 8,
  parameter int unsigned WORDS_PER_LINE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic              i_fill_en,
  input  logic [TAG_W-1:0]  i_fill_tag,
  input  logic [LINE_W-1:0] i_fill_data,
  input  logic              i_wr_en,
  input  logic [OFS_W-1:0]  i_wr_ofs,
  input  logic [WORD_W-1:0] i_wr_data,
  input  logic              i_clr_dirty,
  output logic              o_valid,
  output logic              o_dirty,
  output logic [TAG_W-1:0]  o_tag,
  output logic [LINE_W-1:0] o_data
);

  logic [NUM_SETS-1:0] r_valid;
  logic [NUM_SETS-1:0] r_dirty;
  logic [TAG_W-1:0]    r_tag  [NUM_SETS];
  logic [LINE_W-1:0]   r_data [NUM_SETS];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_fill_en) begin
      r_valid[i_idx] <= 1'b1;
      r_dirty[i_idx] <= 1'b0;
    end else if (i_wr_en) begin
      r_dirty[i_idx] <= 1'b1;
    end else if (i_clr_dirty) begin
      r_dirty[i_idx] <= 1'b0;
    end
  end

  // Contents survive reset; only the valid/dirty flags are cleared.
  always_ff @(posedge clk) begin
    if (i_fill_en) begin
      r_tag[i_idx]  <= i_fill_tag;
      r_data[i_idx] <= i_fill_data;
    end else if (i_wr_en) begin
      for (int unsigned w = 0; w < WORDS_PER_LINE; w++) begin
        if (w == 32'(i_wr_ofs)) r_data[i_idx][w*WORD_W +: WORD_W] <= i_wr_data;
      end
    end
  end

  assign o_valid = r_valid[i_idx];
  assign o_dirty = r_dirty[i_idx];
  assign o_tag   = r_tag[i_idx];
  assign o_data  = r_data[i_idx];

endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-back, write-allocate data cache: FSM and hit logic.
// Optional hit/miss counters are enabled with `define DCACHE_STATS_EN.
module dcache
  import dcache_pkg::*;
#(
  parameter int unsigned NUM_SETS       = 8,
  parameter int unsigned WORDS_PER_LINE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              proc_read,
  input  logic              proc_write,
  input  logic [29:0]       proc_addr,
  input  logic [31:0]       proc_wdata,
  output logic              proc_stall,
  output logic [31:0]       proc_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [27:0]       mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  state_e r_state, w_next;

  logic [OFS_W-1:0]  w_ofs;
  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic              w_valid, w_dirty, w_hit, w_req;
  logic [TAG_W-1:0]  w_tag_st;
  logic [LINE_W-1:0] w_line;
  logic              w_wr_en, w_fill_en, w_clr_dirty;

  assign w_ofs = proc_addr[1:0];
  assign w_idx = proc_addr[4:2];
  assign w_tag = proc_addr[29:5];
  assign w_req = proc_read | proc_write;
  assign w_hit = w_valid && (w_tag_st == w_tag);

  dcache_array #(
    .NUM_SETS       (NUM_SETS),
    .WORDS_PER_LINE (WORDS_PER_LINE)
  ) u_array (
    .clk         (clk),
    .rst         (rst),
    .i_idx       (w_idx),
    .i_fill_en   (w_fill_en),
    .i_fill_tag  (w_tag),
    .i_fill_data (mem_rdata),
    .i_wr_en     (w_wr_en),
    .i_wr_ofs    (w_ofs),
    .i_wr_data   (proc_wdata),
    .i_clr_dirty (w_clr_dirty),
    .o_valid     (w_valid),
    .o_dirty     (w_dirty),
    .o_tag       (w_tag_st),
    .o_data      (w_line)
  );

  assign proc_rdata = w_line[{w_ofs, 5'b0} +: WORD_W];

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    proc_stall  = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    w_wr_en     = 1'b0;
    w_fill_en   = 1'b0;
    w_clr_dirty = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          if (w_hit) begin
            w_wr_en = proc_write;
          end else begin
            proc_stall = 1'b1;
            w_next     = w_dirty ? WRITEBACK : ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        proc_stall = 1'b1;
        mem_write  = 1'b1;
        mem_addr   = {w_tag_st, w_idx};
        mem_wdata  = w_line;
        if (mem_ready) begin
          w_clr_dirty = 1'b1;
          w_next      = ALLOCATE;
        end
      end
      ALLOCATE: begin
        proc_stall = 1'b1;
        mem_read   = 1'b1;
        mem_addr   = proc_addr[29:2];
        if (mem_ready) begin
          w_fill_en = 1'b1;
          w_next    = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

`ifdef DCACHE_STATS_EN
  logic        r_refilled;
  logic [31:0] r_hit_cnt, r_miss_cnt;
  logic        w_idle_req;

  assign w_idle_req = (r_state == IDLE) && w_req;

  // The retried access right after a refill is part of the miss, not a hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_refilled <= 1'b0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      r_refilled <= (r_state == ALLOCATE) && mem_ready;
      if (w_idle_req && !w_hit)               r_miss_cnt <= r_miss_cnt + 32'd1;
      if (w_idle_req && w_hit && !r_refilled) r_hit_cnt  <= r_hit_cnt + 32'd1;
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`endif

endmodule
